// File: rtl/hazard_scoreboard.sv
// Issue controller between Decode and EX: tracks in-flight MUL results, books the shared
// register-file write port and stalls Decode on MUL RAW/WAW, load-use and port hazards.
module hazard_scoreboard #(
   parameter int REG_BITS = 5,
   parameter int MUL_LAT  = 5,
   parameter int ALU_LAT  = 3,
   parameter int CNT_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_D_in,
   input  logic [REG_BITS-1:0] rs1_D_in,
   input  logic [REG_BITS-1:0] rs2_D_in,
   input  logic                use_rs1_D_in,
   input  logic                use_rs2_D_in,
   input  logic [REG_BITS-1:0] rd_D_in,
   input  logic                reg_write_D_in,
   input  logic                is_mul_D_in,
   input  logic                is_load_EX_in,
   input  logic [REG_BITS-1:0] rd_EX_in,
   input  logic                mem_stall_in,
   input  logic                flush_D_in,
   output logic                stall_D_out,
   output logic                issue_out,
   output logic                mul_wb_valid_out,
   output logic [REG_BITS-1:0] mul_rd_wb_out,
   output logic                mul_busy_out,
   output logic [CNT_BITS-1:0] stall_cnt_out
);

   logic                adv;
   logic                live;
   logic                raw_mul;
   logic                waw_mul;
   logic                load_use;
   logic                port_hit;

   logic [MUL_LAT-1:0]  m_valid_q, m_valid_d;
   logic [REG_BITS-1:0] m_rd_q [MUL_LAT];
   logic [REG_BITS-1:0] m_rd_d [MUL_LAT];
   logic [MUL_LAT-1:0]  resv_q, resv_d, resv_set;
   logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

   // Gating adv with rst_n keeps the combinational outputs at 0 while reset is held.
   assign adv  = ~mem_stall_in & rst_n;
   assign live = valid_D_in & ~flush_D_in;

   always_comb begin
      raw_mul = 1'b0;
      waw_mul = 1'b0;
      for (int k = 0; k < MUL_LAT - 1; k++) begin
         if (m_valid_q[k]) begin
            // The last two stages are reached by WB forwarding and RF write-before-read.
            if (k < MUL_LAT - 2) begin
               if (use_rs1_D_in && (rs1_D_in != '0) && (rs1_D_in == m_rd_q[k])) begin
                  raw_mul = 1'b1;
               end
               if (use_rs2_D_in && (rs2_D_in != '0) && (rs2_D_in == m_rd_q[k])) begin
                  raw_mul = 1'b1;
               end
            end
            if (reg_write_D_in && !is_mul_D_in && (rd_D_in != '0) && (rd_D_in == m_rd_q[k])) begin
               waw_mul = 1'b1;
            end
         end
      end

      load_use = is_load_EX_in && (rd_EX_in != '0) &&
                 ((use_rs1_D_in && (rs1_D_in == rd_EX_in)) ||
                  (use_rs2_D_in && (rs2_D_in == rd_EX_in)));

      port_hit = (!is_mul_D_in && reg_write_D_in && resv_q[ALU_LAT-1]) ||
                 (is_mul_D_in && resv_q[MUL_LAT-1]);

      stall_D_out = adv && live && (raw_mul || waw_mul || load_use || port_hit);
      issue_out   = adv && live && !stall_D_out;
   end

   always_comb begin
      m_valid_d = m_valid_q;
      m_rd_d    = m_rd_q;
      resv_d    = resv_q;
      resv_set  = '0;

      if (issue_out && (rd_D_in != '0)) begin
         if (is_mul_D_in) begin
            resv_set[MUL_LAT-1] = 1'b1;
         end else if (reg_write_D_in) begin
            resv_set[ALU_LAT-1] = 1'b1;
         end
      end

      // Bookings are made in this cycle's frame, then everything ages by one slot.
      if (adv) begin
         for (int i = MUL_LAT - 1; i > 0; i--) begin
            m_valid_d[i] = m_valid_q[i-1];
            m_rd_d[i]    = m_rd_q[i-1];
         end
         m_valid_d[0] = issue_out && is_mul_D_in && (rd_D_in != '0);
         m_rd_d[0]    = rd_D_in;
         resv_d       = (resv_q | resv_set) >> 1;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall_D_out && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q   <= '0;
         resv_q      <= '0;
         stall_cnt_q <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            m_rd_q[i] <= '0;
         end
      end else begin
         m_valid_q   <= m_valid_d;
         resv_q      <= resv_d;
         stall_cnt_q <= stall_cnt_d;
         for (int i = 0; i < MUL_LAT; i++) begin
            m_rd_q[i] <= m_rd_d[i];
         end
      end
   end

   assign mul_wb_valid_out = m_valid_q[MUL_LAT-1];
   assign mul_rd_wb_out    = m_rd_q[MUL_LAT-1];
   assign mul_busy_out     = |m_valid_q;
   assign stall_cnt_out    = stall_cnt_q;

endmodule
